// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Holds counter encodings, the entry bundle and the saturating update.
package bp_pkg;

  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = 8;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [29:0]         target;
    logic [1:0]          ctr;
  } bp_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] n;
    if (taken)
      n = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else
      n = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// 2-bit saturating direction counter, one per table entry.
// Load wins over inc/dec; inc and dec together hold the value.
module sat_counter2
  import bp_pkg::*;
#(
  parameter logic [1:0] INIT = CTR_WNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_load,
  input  logic [1:0] i_load_val,
  output logic [1:0] o_ctr
);

  logic [1:0] r_ctr;

  // Counter state: reset to INIT, load on allocate, else saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ctr <= INIT;
    else if (i_load)
      r_ctr <= i_load_val;
    else if (i_inc ^ i_dec)
      r_ctr <= ctr_next(r_ctr, i_inc);
  end

  assign o_ctr = r_ctr;

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB plus 2-bit counter table, looked up on PC_F.
// Optional BP_STATS_EN adds update / mispredict counters.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int         IDX_W    = BP_IDX_W,
  parameter int         TAG_W    = BP_TAG_W,
  parameter logic [1:0] CTR_INIT = CTR_WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic [31:0] PC_F,
  output logic [31:0] pred_target,
  output logic        pred_taken_F,
  input  logic        upd_valid,
  input  logic [31:0] upd_PC_D,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispred
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TLO   = IDX_W + 2;
  localparam int THI   = IDX_W + TAG_W + 1;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [29:0]      r_target [DEPTH];
  logic [1:0]       w_ctr    [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_alloc;

  // Lookup side: pre-update view of the indexed entry.
  assign w_idx = PC_F[IDX_W+1:2];
  assign w_tag = PC_F[THI:TLO];
  assign w_hit = r_valid[w_idx]
              && (r_tag[w_idx] == w_tag);

  assign pred_taken_F = w_hit && w_ctr[w_idx][1];
  assign pred_target  = pred_taken_F
                      ? {r_target[w_idx], 2'b00}
                      : PC_F + 32'd4;

  // Update side: decoded from the resolved PC.
  assign w_u_idx = upd_PC_D[IDX_W+1:2];
  assign w_u_tag = upd_PC_D[THI:TLO];
  assign w_u_hit = r_valid[w_u_idx]
                && (r_tag[w_u_idx] == w_u_tag);
  assign w_alloc = !w_u_hit && upd_taken;

  // Valid/tag/target: taken writes target, miss also claims the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      r_target[w_u_idx] <= upd_target[31:2];
      if (!w_u_hit) begin
        r_valid[w_u_idx] <= 1'b1;
        r_tag[w_u_idx]   <= w_u_tag;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    logic w_sel;
    assign w_sel = upd_valid
                && (w_u_idx == IDX_W'(g));
    sat_counter2 #(
      .INIT(CTR_INIT)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .i_inc     (w_sel && w_u_hit && upd_taken),
      .i_dec     (w_sel && w_u_hit && !upd_taken),
      .i_load    (w_sel && w_alloc),
      .i_load_val(CTR_WT),
      .o_ctr     (w_ctr[g])
    );
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_mis;

  // Free-running event counters, wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (upd_valid) begin
      r_stat_upd <= r_stat_upd + 32'd1;
      if (upd_mispred)
        r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_updates = r_stat_upd;
  assign stat_mispred = r_stat_mis;

  logic w_unused_ok;
  assign w_unused_ok = ^{stall_F,
                         PC_F[31:THI+1],
                         PC_F[1:0],
                         upd_PC_D[31:THI+1],
                         upd_PC_D[1:0],
                         upd_target[1:0]};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{stall_F,
                         upd_mispred,
                         PC_F[31:THI+1],
                         PC_F[1:0],
                         upd_PC_D[31:THI+1],
                         upd_PC_D[1:0],
                         upd_target[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed literals plus random traffic.
// A table-level model is compared against the DUT every cycle.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_F = 1'b0;
  logic [31:0] PC_F = 32'h40;
  logic [31:0] pred_target;
  logic        pred_taken_F;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_PC_D = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk         (clk),
    .rst         (rst),
    .stall_F     (stall_F),
    .PC_F        (PC_F),
    .pred_target (pred_target),
    .pred_taken_F(pred_taken_F),
    .upd_valid   (upd_valid),
    .upd_PC_D    (upd_PC_D),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred)
`ifdef BP_STATS_EN
    ,
    .stat_updates(stat_updates),
    .stat_mispred(stat_mispred)
`endif
  );

  // Reference table: 64 slots, counter kept as an integer 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_upd = 0;
  logic [31:0] m_mis = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic void m_look(input logic [31:0] pc,
                                 output logic t,
                                 output logic [31:0] tg);
    int i;
    bit hit;
    i   = int'((pc / 4) % 64);
    hit = m_valid[i] && (m_tag[i] == (pc / 256) % 256);
    t   = hit && (m_ctr[i] >= 2);
    tg  = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_upd = 0;
      m_mis = 0;
    end else if (upd_valid) begin
      int i;
      bit hit;
      i   = int'((upd_PC_D / 4) % 64);
      hit = m_valid[i]
         && (m_tag[i] == (upd_PC_D / 256) % 256);
      m_upd = m_upd + 1;
      if (upd_mispred) m_mis = m_mis + 1;
      if (hit && upd_taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = upd_target & 32'hFFFF_FFFC;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (upd_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = (upd_PC_D / 256) % 256;
        m_tgt[i]   = upd_target & 32'hFFFF_FFFC;
        m_ctr[i]   = 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        et;
    logic [31:0] eg;
    m_look(PC_F, et, eg);
    chk("model_taken", {31'd0, pred_taken_F}, {31'd0, et});
    chk("model_target", pred_target, eg);
`ifdef BP_STATS_EN
    chk("model_stat_upd", stat_updates, m_upd);
    chk("model_stat_mis", stat_mispred, m_mis);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic tk,
                     input logic [31:0] tg,
                     input logic mp);
    upd_valid   = 1'b1;
    upd_PC_D    = pc;
    upd_taken   = tk;
    upd_target  = tg;
    upd_mispred = mp;
  endtask

  task automatic noupd();
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic lit(input string nm,
                     input logic t,
                     input logic [31:0] tg);
    @(negedge clk);
    chk({nm, "_taken"}, {31'd0, pred_taken_F}, {31'd0, t});
    chk({nm, "_target"}, pred_target, tg);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noupd();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    PC_F = 32'h40;
    lit("reset", 1'b0, 32'h44);
    tick();
    rst = 1'b0;

    // Same-cycle update on a cold table, with stall held.
    stall_F = 1'b1;
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    lit("same_cyc", 1'b0, 32'h44);
    tick();
    noupd();
    lit("alloc", 1'b1, 32'h100);
    stall_F = 1'b0;

    // Saturate to 3, then walk down.
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 1'b1, 32'h100, 1'b0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      upd(32'h40, 1'b0, 32'h0, 1'b1);
      tick();
    end
    noupd();
    lit("ctr_wnt", 1'b0, 32'h44);
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 1'b0, 32'h0, 1'b0);
      tick();
    end
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    tick();
    noupd();
    lit("ctr_floor", 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h104, 1'b0);
    tick();
    noupd();
    lit("ctr_back", 1'b1, 32'h104);

    // Alias on same index, different tag.
    PC_F = 32'h140;
    lit("alias_miss", 1'b0, 32'h144);
    tick();
    upd(32'h140, 1'b1, 32'h203, 1'b0);
    tick();
    noupd();
    lit("alias_new", 1'b1, 32'h200);
    PC_F = 32'h40;
    lit("alias_old", 1'b0, 32'h44);
    tick();

    // PC wrap on a cold table.
    do_reset();
    PC_F = 32'hFFFF_FFFC;
    lit("wrap", 1'b0, 32'h0);
    tick();

`ifdef BP_STATS_EN
    for (int k = 0; k < 5; k++) begin
      upd(32'h80 + 32'(k * 4), k[0], 32'h300, k < 2);
      tick();
    end
    noupd();
    @(negedge clk);
    chk("stat_upd5", stat_updates, 32'd5);
    chk("stat_mis2", stat_mispred, 32'd2);
    rst = 1'b1;
    #1;
    chk("stat_upd_rst", stat_updates, 32'd0);
    chk("stat_mis_rst", stat_mispred, 32'd0);
    tick();
    rst = 1'b0;
`endif

    // Random traffic over a small PC pool to get hits and aliases.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pa;
      logic [31:0] pb;
      pa = ($urandom_range(0, 3) << 8)
         | ($urandom_range(0, 7) << 2)
         | $urandom_range(0, 3);
      pb = ($urandom_range(0, 3) << 8)
         | ($urandom_range(0, 7) << 2)
         | $urandom_range(0, 3);
      if ($urandom_range(0, 50) == 0) pa = 32'hFFFF_FFFC;
      PC_F    = pa;
      stall_F = $urandom_range(0, 3) == 0;
      rst     = $urandom_range(0, 150) == 0;
      if ($urandom_range(0, 1) == 1)
        upd(pb, $urandom_range(0, 2) != 0,
            $urandom, $urandom_range(0, 1) == 1);
      else
        noupd();
      tick();
    end
    rst = 1'b0;
    noupd();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
